// File: rtl/kart_motion.sv
// -----------------------------------------------------------------------------
// kart_motion
//   Per-frame kinematic state generator for the player kart. On each frame
//   pulse it latches the buttons and terrain flag, then over four cycles it
//   turns, updates speed, advances a sub-pixel position along the heading and
//   publishes the new state with a one-cycle strobe.
//
// Ports
//   clk_in        system clock
//   rst_in_n      asynchronous active-low reset
//   new_frame_in  one-cycle frame-start pulse (ignored while an update runs)
//   accel_in      accelerate button
//   brake_in      brake button
//   left_in       turn-left button
//   right_in      turn-right button
//   on_track_in   1 = kart is on road surface
//   direction     heading in degrees, 0..345 in steps of 15 (0 = +x, 90 = +y)
//   player_x      integer X map position
//   player_y      integer Y map position
//   speed_out     current speed
//   update_out    high for the single cycle in which the outputs take new values
// -----------------------------------------------------------------------------
module kart_motion #(
  parameter int unsigned START_X     = 191,
  parameter int unsigned START_Y     = 191,
  parameter int unsigned START_DIR   = 270,
  parameter int unsigned MAP_MAX     = 1023,
  parameter int unsigned MAX_SPEED   = 15,
  parameter int unsigned OFFROAD_MAX = 4
) (
  input  logic        clk_in,
  input  logic        rst_in_n,
  input  logic        new_frame_in,
  input  logic        accel_in,
  input  logic        brake_in,
  input  logic        left_in,
  input  logic        right_in,
  input  logic        on_track_in,
  output logic [8:0]  direction,
  output logic [10:0] player_x,
  output logic [10:0] player_y,
  output logic [3:0]  speed_out,
  output logic        update_out
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_TURN,
    S_SPEED,
    S_MOVE,
    S_WRITE
  } state_t;

  // Heading is kept as a 15-degree step index (0..23).
  localparam logic [4:0]  START_IDX = 5'(START_DIR / 15);
  localparam logic [3:0]  MAX_SPD   = 4'(MAX_SPEED);
  localparam logic [3:0]  OFF_MAX   = 4'(OFFROAD_MAX);
  localparam logic [10:0] MAP_LIM   = 11'(MAP_MAX);
  // Positions are 11.7 fixed point.
  localparam logic [17:0] START_PX  = {11'(START_X), 7'd0};
  localparam logic [17:0] START_PY  = {11'(START_Y), 7'd0};

  // Quarter-wave sine in Q1.7, 0..90 degrees in 15-degree steps.
  function automatic logic [7:0] quarter_sine(input logic [2:0] idx);
    case (idx)
      3'd0:    return 8'd0;
      3'd1:    return 8'd33;
      3'd2:    return 8'd64;
      3'd3:    return 8'd91;
      3'd4:    return 8'd111;
      3'd5:    return 8'd124;
      3'd6:    return 8'd128;
      default: return 8'd0;
    endcase
  endfunction

  // Bit 18 is the sign of the 19-bit sum. MAP_MAX + MAX_SPEED below 2048 keeps
  // a positive overshoot clear of that bit.
  function automatic logic [17:0] clamp_pos(input logic [18:0] sum);
    if (sum[18])             return '0;
    if (sum[17:7] > MAP_LIM) return {MAP_LIM, 7'd0};
    return sum[17:0];
  endfunction

  state_t       r_state, w_state_next;
  logic         r_accel, r_brake, r_left, r_right, r_on_track;
  logic [4:0]   r_dir_idx, w_dir_turn;
  logic [3:0]   r_speed, w_speed_btn, w_speed_next, w_accel_cap;
  logic [1:0]   r_coast, w_coast_next;
  logic [17:0]  r_pos_x, r_pos_y, w_new_x, w_new_y;
  logic [1:0]   w_quad;
  logic [2:0]   w_sub;
  logic signed [8:0]  w_lut_s, w_lut_c, w_cos, w_sin;
  logic signed [11:0] w_spd12, w_cos12, w_sin12, w_dx, w_dy;
  logic [18:0]  w_sum_x, w_sum_y;
  logic [8:0]   w_dir_deg;

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  // NOTE: state-holding logic uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) r_state <= S_IDLE;
    else           r_state <= w_state_next;
  end

  // NOTE: every combinational output gets a default first, so no path through
  // the block leaves a variable unassigned and a latch is never inferred.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (new_frame_in) w_state_next = S_TURN;
      S_TURN:  w_state_next = S_SPEED;
      S_SPEED: w_state_next = S_MOVE;
      S_MOVE:  w_state_next = S_WRITE;
      S_WRITE: w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  assign update_out = (r_state == S_WRITE);

  // ---------------------------------------------------------------------------
  // Heading
  // ---------------------------------------------------------------------------
  always_comb begin
    w_dir_turn = r_dir_idx;
    if (r_right && !r_left)      w_dir_turn = (r_dir_idx == 5'd23) ? 5'd0  : r_dir_idx + 5'd1;
    else if (r_left && !r_right) w_dir_turn = (r_dir_idx == 5'd0)  ? 5'd23 : r_dir_idx - 5'd1;
  end

  assign w_dir_deg = 9'(r_dir_idx) * 9'd15;

  // ---------------------------------------------------------------------------
  // Speed. Accel never pushes past the off-track cap; any excess above the cap
  // while off track bleeds away by one per frame, which is what makes held
  // accel a net -1 off road.
  // ---------------------------------------------------------------------------
  assign w_accel_cap = r_on_track ? MAX_SPD : OFF_MAX;

  always_comb begin
    w_speed_btn  = r_speed;
    w_coast_next = r_coast;
    if (r_brake) begin
      w_speed_btn  = (r_speed >= 4'd2) ? r_speed - 4'd2 : 4'd0;
      w_coast_next = 2'd0;
    end else if (r_accel) begin
      w_speed_btn  = (r_speed < w_accel_cap) ? r_speed + 4'd1 : r_speed;
      w_coast_next = 2'd0;
    end else begin
      w_coast_next = r_coast + 2'd1;
      if (r_coast == 2'd3 && r_speed != 4'd0) w_speed_btn = r_speed - 4'd1;
    end
    w_speed_next = w_speed_btn;
    if (!r_on_track && w_speed_btn > OFF_MAX) w_speed_next = w_speed_btn - 4'd1;
  end

  // ---------------------------------------------------------------------------
  // Motion: quadrant folding of the quarter-wave table, then Q.7 deltas.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_quad = 2'd3;
    w_sub  = 3'(r_dir_idx - 5'd18);
    if (r_dir_idx < 5'd6) begin
      w_quad = 2'd0;
      w_sub  = r_dir_idx[2:0];
    end else if (r_dir_idx < 5'd12) begin
      w_quad = 2'd1;
      w_sub  = 3'(r_dir_idx - 5'd6);
    end else if (r_dir_idx < 5'd18) begin
      w_quad = 2'd2;
      w_sub  = 3'(r_dir_idx - 5'd12);
    end
  end

  assign w_lut_s = $signed({1'b0, quarter_sine(w_sub)});
  assign w_lut_c = $signed({1'b0, quarter_sine(3'd6 - w_sub)});

  always_comb begin
    w_cos = w_lut_c;
    w_sin = w_lut_s;
    case (w_quad)
      2'd1:    begin w_cos = -w_lut_s; w_sin =  w_lut_c; end
      2'd2:    begin w_cos = -w_lut_c; w_sin = -w_lut_s; end
      2'd3:    begin w_cos =  w_lut_s; w_sin = -w_lut_c; end
      default: begin w_cos =  w_lut_c; w_sin =  w_lut_s; end
    endcase
  end

  assign w_spd12 = $signed({8'd0, r_speed});
  assign w_cos12 = {{3{w_cos[8]}}, w_cos};
  assign w_sin12 = {{3{w_sin[8]}}, w_sin};
  assign w_dx    = w_spd12 * w_cos12;
  assign w_dy    = w_spd12 * w_sin12;

  assign w_sum_x = {1'b0, r_pos_x} + {{7{w_dx[11]}}, w_dx};
  assign w_sum_y = {1'b0, r_pos_y} + {{7{w_dy[11]}}, w_dy};
  assign w_new_x = clamp_pos(w_sum_x);
  assign w_new_y = clamp_pos(w_sum_y);

  // ---------------------------------------------------------------------------
  // Datapath registers. The published outputs load only on the MOVE -> WRITE
  // edge, so a reset part-way through a frame never exposes a partial update.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) begin
      r_accel    <= 1'b0;
      r_brake    <= 1'b0;
      r_left     <= 1'b0;
      r_right    <= 1'b0;
      r_on_track <= 1'b0;
      r_dir_idx  <= START_IDX;
      r_speed    <= 4'd0;
      r_coast    <= 2'd0;
      r_pos_x    <= START_PX;
      r_pos_y    <= START_PY;
      direction  <= 9'(START_DIR);
      player_x   <= 11'(START_X);
      player_y   <= 11'(START_Y);
      speed_out  <= 4'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (new_frame_in) begin
            r_accel    <= accel_in;
            r_brake    <= brake_in;
            r_left     <= left_in;
            r_right    <= right_in;
            r_on_track <= on_track_in;
          end
        end
        S_TURN:  r_dir_idx <= w_dir_turn;
        S_SPEED: begin
          r_speed <= w_speed_next;
          r_coast <= w_coast_next;
        end
        S_MOVE: begin
          r_pos_x   <= w_new_x;
          r_pos_y   <= w_new_y;
          direction <= w_dir_deg;
          player_x  <= w_new_x[17:7];
          player_y  <= w_new_y[17:7];
          speed_out <= r_speed;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_kart_motion.sv
// -----------------------------------------------------------------------------
// tb_kart_motion
//   Directed bench for kart_motion. The main instance uses default parameters;
//   two extra instances share the same stimulus and start against the map
//   edges (x 1020 heading 0, x 3 heading 180) to exercise both clamps.
// -----------------------------------------------------------------------------
module tb_kart_motion;

  logic clk = 1'b0;
  logic rst_n, nf, accel, brake, left, right, on_track;

  logic [8:0]  dir,  dir_hi,  dir_lo;
  logic [10:0] px,   px_hi,   px_lo;
  logic [10:0] py,   py_hi,   py_lo;
  logic [3:0]  spd,  spd_hi,  spd_lo;
  logic        upd,  upd_hi,  upd_lo;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  kart_motion dut (
    .clk_in(clk), .rst_in_n(rst_n), .new_frame_in(nf), .accel_in(accel),
    .brake_in(brake), .left_in(left), .right_in(right), .on_track_in(on_track),
    .direction(dir), .player_x(px), .player_y(py), .speed_out(spd), .update_out(upd)
  );

  kart_motion #(.START_X(1020), .START_DIR(0)) u_edge_hi (
    .clk_in(clk), .rst_in_n(rst_n), .new_frame_in(nf), .accel_in(accel),
    .brake_in(brake), .left_in(left), .right_in(right), .on_track_in(on_track),
    .direction(dir_hi), .player_x(px_hi), .player_y(py_hi), .speed_out(spd_hi),
    .update_out(upd_hi)
  );

  kart_motion #(.START_X(3), .START_DIR(180)) u_edge_lo (
    .clk_in(clk), .rst_in_n(rst_n), .new_frame_in(nf), .accel_in(accel),
    .brake_in(brake), .left_in(left), .right_in(right), .on_track_in(on_track),
    .direction(dir_lo), .player_x(px_lo), .player_y(py_lo), .speed_out(spd_lo),
    .update_out(upd_lo)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_state(input string tag, input int e_dir, input int e_x,
                             input int e_y, input int e_spd);
    check({tag, " dir"},   32'(dir), 32'(e_dir));
    check({tag, " x"},     32'(px),  32'(e_x));
    check({tag, " y"},     32'(py),  32'(e_y));
    check({tag, " speed"}, 32'(spd), 32'(e_spd));
  endtask

  // One frame: buttons valid only in the frame-pulse cycle, inverted afterwards
  // to show they are not resampled. Returns at cycle N+5 with outputs settled.
  task automatic run_frame(input logic a, input logic b, input logic l,
                           input logic r, input logic t);
    int lat;
    @(negedge clk);
    accel = a; brake = b; left = l; right = r; on_track = t; nf = 1'b1;
    @(negedge clk);
    nf = 1'b0;
    accel = ~a; brake = ~b; left = ~l; right = ~r; on_track = ~t;
    lat = 1;
    while (upd !== 1'b1 && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    check("update latency", 32'(lat), 32'd4);
    @(negedge clk);
    check("update one-shot", 32'(upd), 32'd0);
    accel = 1'b0; brake = 1'b0; left = 1'b0; right = 1'b0; on_track = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc_spd [3]  = '{1, 2, 3};
    int acc_y   [3]  = '{190, 188, 185};
    int hi_x    [3]  = '{1021, 1023, 1023};
    int lo_x    [3]  = '{2, 0, 0};
    int turn_d  [5]  = '{285, 300, 315, 330, 345};
    int run_x   [10] = '{192, 194, 197, 201, 206, 212, 219, 227, 236, 246};
    int off_spd [7]  = '{9, 8, 7, 6, 5, 4, 4};
    int off_x   [7]  = '{255, 263, 270, 276, 281, 285, 289};
    int cst_spd [12] = '{4, 4, 4, 3, 3, 3, 3, 2, 2, 2, 2, 1};
    int cst_x   [12] = '{293, 297, 301, 304, 307, 310, 313, 315, 317, 319, 321, 322};
    int n_upd, upd_at;

    rst_n = 1'b0; nf = 1'b0; accel = 1'b0; brake = 1'b0;
    left = 1'b0; right = 1'b0; on_track = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Reset: move away from reset state, then pulse reset mid-cycle.
    run_frame(1, 0, 0, 0, 1);
    check("pre-reset speed", 32'(spd), 32'd1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_state("async reset", 270, 191, 191, 0);
    check("async reset update", 32'(upd), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Straight acceleration plus edge clamps on the side instances.
    for (int i = 0; i < 3; i++) begin
      run_frame(1, 0, 0, 0, 1);
      check_state("accel", 270, 191, acc_y[i], acc_spd[i]);
      check("clamp high x", 32'(px_hi), 32'(hi_x[i]));
      check("clamp low x",  32'(px_lo), 32'(lo_x[i]));
    end

    // Stop, then heading wrap.
    run_frame(0, 1, 0, 0, 1);
    check_state("brake 3", 270, 191, 184, 1);
    run_frame(0, 1, 0, 0, 1);
    check_state("brake 1", 270, 191, 184, 0);
    for (int i = 0; i < 5; i++) begin
      run_frame(0, 0, 0, 1, 1);
      check("turn right dir", 32'(dir), 32'(turn_d[i]));
    end
    run_frame(0, 0, 0, 1, 1);
    check_state("wrap 345->0", 0, 191, 184, 0);
    run_frame(0, 0, 1, 0, 1);
    check("wrap 0->345", 32'(dir), 32'd345);
    run_frame(0, 0, 1, 1, 1);
    check("both buttons", 32'(dir), 32'd345);
    run_frame(0, 0, 0, 1, 1);
    check("face +x", 32'(dir), 32'd0);

    // Build speed 10 along +x, then off-road, coast and brake.
    for (int i = 0; i < 10; i++) begin
      run_frame(1, 0, 0, 0, 1);
      check("run speed", 32'(spd), 32'(i + 1));
      check("run x",     32'(px),  32'(run_x[i]));
    end
    check("run y", 32'(py), 32'd184);
    for (int i = 0; i < 7; i++) begin
      run_frame(1, 0, 0, 0, 0);
      check("offroad speed", 32'(spd), 32'(off_spd[i]));
      check("offroad x",     32'(px),  32'(off_x[i]));
    end
    for (int i = 0; i < 12; i++) begin
      run_frame(0, 0, 0, 0, 1);
      check("coast speed", 32'(spd), 32'(cst_spd[i]));
      check("coast x",     32'(px),  32'(cst_x[i]));
    end
    run_frame(0, 1, 0, 0, 1);
    check_state("brake at 1", 0, 322, 184, 0);

    // Busy: a second pulse at N+2 must be ignored.
    @(negedge clk);
    nf = 1'b1; accel = 1'b1;
    n_upd = 0; upd_at = -1;
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      nf = (i == 2); accel = 1'b0;
      if (upd === 1'b1) begin
        n_upd++;
        if (upd_at < 0) upd_at = i;
      end
    end
    check("busy update count", 32'(n_upd), 32'd1);
    check("busy update cycle", 32'(upd_at), 32'd4);
    check_state("busy frame", 0, 323, 184, 1);

    // Reset during MOVE: no strobe, outputs back to reset values.
    @(negedge clk);
    nf = 1'b1; accel = 1'b1;
    n_upd = 0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      nf = 1'b0; accel = 1'b0;
      if (upd === 1'b1) n_upd++;
      if (i == 3) begin
        rst_n = 1'b0;
        #1;
        check_state("reset mid-frame", 270, 191, 191, 0);
      end
      if (i == 5) rst_n = 1'b1;
    end
    check("reset mid-frame updates", 32'(n_upd), 32'd0);
    run_frame(1, 0, 0, 0, 1);
    check_state("after reset frame", 270, 191, 190, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
